// File: rtl/umai_arbiter2.sv
// Two-master UMAI arbiter: round-robin write/read command arbitration with
// order queues that steer write data and return read data per granted command.

module umai_arb2_order_q #(
  parameter int Depth = 4,
  parameter int W     = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign o_full  = (cnt_q == CW'(Depth));
  assign o_empty = (cnt_q == '0);
  assign o_head  = mem_q[rptr_q];
  // full is taken from registered occupancy, so a same-cycle pop never frees a slot for the push
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q] <= i_push_data;
  end
endmodule

module umai_arbiter2 #(
  parameter int OrderDepth = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_m0_wcmd_valid,
  output logic         o_m0_wcmd_ready,
  input  logic [31:0]  i_m0_wcmd_addr,
  input  logic [5:0]   i_m0_wcmd_len,
  input  logic         i_m1_wcmd_valid,
  output logic         o_m1_wcmd_ready,
  input  logic [31:0]  i_m1_wcmd_addr,
  input  logic [5:0]   i_m1_wcmd_len,
  input  logic         i_m0_rcmd_valid,
  output logic         o_m0_rcmd_ready,
  input  logic [31:0]  i_m0_rcmd_addr,
  input  logic [5:0]   i_m0_rcmd_len,
  input  logic         i_m1_rcmd_valid,
  output logic         o_m1_rcmd_ready,
  input  logic [31:0]  i_m1_rcmd_addr,
  input  logic [5:0]   i_m1_rcmd_len,
  input  logic         i_m0_wvalid,
  output logic         o_m0_wready,
  input  logic [511:0] i_m0_wdata,
  input  logic         i_m1_wvalid,
  output logic         o_m1_wready,
  input  logic [511:0] i_m1_wdata,
  output logic         o_m0_rvalid,
  input  logic         i_m0_rready,
  output logic [511:0] o_m0_rdata,
  output logic         o_m1_rvalid,
  input  logic         i_m1_rready,
  output logic [511:0] o_m1_rdata,
  output logic         o_s_wcmd_valid,
  input  logic         i_s_wcmd_ready,
  output logic [31:0]  o_s_wcmd_addr,
  output logic [5:0]   o_s_wcmd_len,
  output logic         o_s_rcmd_valid,
  input  logic         i_s_rcmd_ready,
  output logic [31:0]  o_s_rcmd_addr,
  output logic [5:0]   o_s_rcmd_len,
  output logic         o_s_wvalid,
  input  logic         i_s_wready,
  output logic [511:0] o_s_wdata,
  input  logic         i_s_rvalid,
  output logic         o_s_rready,
  input  logic [511:0] i_s_rdata
);
  logic       wrr_q, wrr_d, rrr_q, rrr_d;
  logic [5:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

  logic       wq_full, wq_empty, rq_full, rq_empty;
  logic [6:0] wq_head, rq_head;

  logic       wgnt_any, wgnt_id, rgnt_any, rgnt_id;
  logic       wcmd_hs, rcmd_hs;
  logic       wh_id, rh_id;
  logic       wd_hs, wd_last, rd_hs, rd_last;

  // Command grants are forced off during reset so every output reads 0 immediately.
  assign wgnt_any = (i_m0_wcmd_valid | i_m1_wcmd_valid) & ~i_rst;
  assign wgnt_id  = i_m1_wcmd_valid & (wrr_q | ~i_m0_wcmd_valid);
  assign rgnt_any = (i_m0_rcmd_valid | i_m1_rcmd_valid) & ~i_rst;
  assign rgnt_id  = i_m1_rcmd_valid & (rrr_q | ~i_m0_rcmd_valid);

  assign o_s_wcmd_valid  = wgnt_any & ~wq_full;
  assign o_s_wcmd_addr   = wgnt_any ? (wgnt_id ? i_m1_wcmd_addr : i_m0_wcmd_addr) : '0;
  assign o_s_wcmd_len    = wgnt_any ? (wgnt_id ? i_m1_wcmd_len : i_m0_wcmd_len) : '0;
  assign o_m0_wcmd_ready = wgnt_any & ~wgnt_id & i_s_wcmd_ready & ~wq_full;
  assign o_m1_wcmd_ready = wgnt_any & wgnt_id & i_s_wcmd_ready & ~wq_full;
  assign wcmd_hs         = o_s_wcmd_valid & i_s_wcmd_ready;

  assign o_s_rcmd_valid  = rgnt_any & ~rq_full;
  assign o_s_rcmd_addr   = rgnt_any ? (rgnt_id ? i_m1_rcmd_addr : i_m0_rcmd_addr) : '0;
  assign o_s_rcmd_len    = rgnt_any ? (rgnt_id ? i_m1_rcmd_len : i_m0_rcmd_len) : '0;
  assign o_m0_rcmd_ready = rgnt_any & ~rgnt_id & i_s_rcmd_ready & ~rq_full;
  assign o_m1_rcmd_ready = rgnt_any & rgnt_id & i_s_rcmd_ready & ~rq_full;
  assign rcmd_hs         = o_s_rcmd_valid & i_s_rcmd_ready;

  umai_arb2_order_q #(.Depth(OrderDepth), .W(7)) u_wq (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (wcmd_hs),
    .i_push_data ({wgnt_id, o_s_wcmd_len}),
    .i_pop       (wd_last),
    .o_full      (wq_full),
    .o_empty     (wq_empty),
    .o_head      (wq_head)
  );

  umai_arb2_order_q #(.Depth(OrderDepth), .W(7)) u_rq (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (rcmd_hs),
    .i_push_data ({rgnt_id, o_s_rcmd_len}),
    .i_pop       (rd_last),
    .o_full      (rq_full),
    .o_empty     (rq_empty),
    .o_head      (rq_head)
  );

  assign wh_id       = wq_head[6];
  assign o_s_wvalid  = ~wq_empty & (wh_id ? i_m1_wvalid : i_m0_wvalid);
  assign o_s_wdata   = wq_empty ? '0 : (wh_id ? i_m1_wdata : i_m0_wdata);
  assign o_m0_wready = ~wq_empty & ~wh_id & i_s_wready;
  assign o_m1_wready = ~wq_empty & wh_id & i_s_wready;
  assign wd_hs       = o_s_wvalid & i_s_wready;
  assign wd_last     = wd_hs & (wcnt_q == wq_head[5:0]);

  assign rh_id       = rq_head[6];
  assign o_s_rready  = ~rq_empty & (rh_id ? i_m1_rready : i_m0_rready);
  assign o_m0_rvalid = ~rq_empty & ~rh_id & i_s_rvalid;
  assign o_m1_rvalid = ~rq_empty & rh_id & i_s_rvalid;
  assign o_m0_rdata  = rq_empty ? '0 : i_s_rdata;
  assign o_m1_rdata  = rq_empty ? '0 : i_s_rdata;
  assign rd_hs       = i_s_rvalid & o_s_rready;
  assign rd_last     = rd_hs & (rcnt_q == rq_head[5:0]);

  always_comb begin
    wrr_d  = wrr_q;
    rrr_d  = rrr_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    if (wcmd_hs) wrr_d = ~wgnt_id;
    if (rcmd_hs) rrr_d = ~rgnt_id;
    if (wd_hs)   wcnt_d = wd_last ? 6'd0 : wcnt_q + 6'd1;
    if (rd_hs)   rcnt_d = rd_last ? 6'd0 : rcnt_q + 6'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrr_q  <= 1'b0;
      rrr_q  <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      wrr_q  <= wrr_d;
      rrr_q  <= rrr_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end
endmodule

// File: tb/tb_umai_arbiter2.sv
// Randomized bench for umai_arbiter2: drivers model two masters and a slave;
// a scoreboard predicts grants, steering and beat order from the arbitration rules.

module tb_umai_arbiter2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         wcv [2], rcv [2], wv [2], mrdy [2];
  logic [31:0]  wca [2], rca [2];
  logic [5:0]   wcl [2], rcl [2];
  logic [511:0] wd  [2];
  logic         wcr [2], rcr [2], wrdy [2], rv [2];
  logic [511:0] rd  [2];

  logic         s_wcr, s_rcr, s_wr, s_rv;
  logic [511:0] s_rd;
  logic         o_s_wcmd_valid, o_s_rcmd_valid, o_s_wvalid, o_s_rready;
  logic [31:0]  o_s_wcmd_addr, o_s_rcmd_addr;
  logic [5:0]   o_s_wcmd_len, o_s_rcmd_len;
  logic [511:0] o_s_wdata;

  umai_arbiter2 #(.OrderDepth(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_wcmd_valid(wcv[0]), .o_m0_wcmd_ready(wcr[0]), .i_m0_wcmd_addr(wca[0]), .i_m0_wcmd_len(wcl[0]),
    .i_m1_wcmd_valid(wcv[1]), .o_m1_wcmd_ready(wcr[1]), .i_m1_wcmd_addr(wca[1]), .i_m1_wcmd_len(wcl[1]),
    .i_m0_rcmd_valid(rcv[0]), .o_m0_rcmd_ready(rcr[0]), .i_m0_rcmd_addr(rca[0]), .i_m0_rcmd_len(rcl[0]),
    .i_m1_rcmd_valid(rcv[1]), .o_m1_rcmd_ready(rcr[1]), .i_m1_rcmd_addr(rca[1]), .i_m1_rcmd_len(rcl[1]),
    .i_m0_wvalid(wv[0]), .o_m0_wready(wrdy[0]), .i_m0_wdata(wd[0]),
    .i_m1_wvalid(wv[1]), .o_m1_wready(wrdy[1]), .i_m1_wdata(wd[1]),
    .o_m0_rvalid(rv[0]), .i_m0_rready(mrdy[0]), .o_m0_rdata(rd[0]),
    .o_m1_rvalid(rv[1]), .i_m1_rready(mrdy[1]), .o_m1_rdata(rd[1]),
    .o_s_wcmd_valid(o_s_wcmd_valid), .i_s_wcmd_ready(s_wcr), .o_s_wcmd_addr(o_s_wcmd_addr), .o_s_wcmd_len(o_s_wcmd_len),
    .o_s_rcmd_valid(o_s_rcmd_valid), .i_s_rcmd_ready(s_rcr), .o_s_rcmd_addr(o_s_rcmd_addr), .o_s_rcmd_len(o_s_rcmd_len),
    .o_s_wvalid(o_s_wvalid), .i_s_wready(s_wr), .o_s_wdata(o_s_wdata),
    .i_s_rvalid(s_rv), .o_s_rready(o_s_rready), .i_s_rdata(s_rd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_checks++;
    $display("FAIL %s: got unexpected event want none", nm);
  endtask

  function automatic logic [511:0] beat_data(input logic [31:0] tag, input int k);
    logic [31:0] w;
    w = tag ^ (32'(k) * 32'h9E3779B9);
    return {16{w}};
  endfunction

  // stimulus knobs (percentages)
  int p_cmd = 60, p_act = 70, p_srdy = 70, p_sdat = 70;
  bit gen_en = 1'b1;

  function automatic bit roll(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  len;
  } cmd_t;

  logic [511:0] wbq0 [$];
  logic [511:0] wbq1 [$];
  cmd_t         srq [$];
  int           sbeat = 0;
  bit           f_wc [2], f_rc [2], f_wd [2];
  bit           f_src, f_sr;
  cmd_t         src;

  task automatic new_wcmd(input int m);
    wcv[m] = 1'b1;
    wca[m] = $urandom;
    wcl[m] = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
  endtask

  task automatic new_rcmd(input int m);
    rcv[m] = 1'b1;
    rca[m] = $urandom;
    rcl[m] = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
  endtask

  // driver: masters and slave; samples handshakes at negedge, updates just after posedge
  initial begin
    for (int m = 0; m < 2; m++) begin
      wcv[m] = 0; rcv[m] = 0; wv[m] = 0; mrdy[m] = 0;
      wca[m] = '0; rca[m] = '0; wcl[m] = '0; rcl[m] = '0; wd[m] = '0;
    end
    s_wcr = 0; s_rcr = 0; s_wr = 0; s_rv = 0; s_rd = '0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        f_wc[m] = wcv[m] && wcr[m];
        f_rc[m] = rcv[m] && rcr[m];
        f_wd[m] = wv[m] && wrdy[m];
      end
      f_src = o_s_rcmd_valid && s_rcr;
      src.addr = o_s_rcmd_addr;
      src.len  = o_s_rcmd_len;
      f_sr = s_rv && o_s_rready;
      @(posedge clk);
      #1;
      if (rst) begin
        wbq0.delete();
        wbq1.delete();
        srq.delete();
        sbeat = 0;
        for (int m = 0; m < 2; m++) begin
          new_wcmd(m);
          new_rcmd(m);
          wv[m] = 0;
          wd[m] = '0;
        end
        s_rv = 0;
        s_rd = '0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (f_wc[m]) begin
            for (int k = 0; k <= int'(wcl[m]); k++) begin
              if (m == 0) wbq0.push_back(beat_data(wca[m], k));
              else        wbq1.push_back(beat_data(wca[m], k));
            end
            wcv[m] = 0;
          end
          if (f_rc[m]) rcv[m] = 0;
          if (f_wd[m]) begin
            if (m == 0) void'(wbq0.pop_front());
            else        void'(wbq1.pop_front());
          end
        end
        if (f_src) srq.push_back(src);
        if (f_sr) begin
          sbeat++;
          if (sbeat > int'(srq[0].len)) begin
            void'(srq.pop_front());
            sbeat = 0;
          end
        end
        for (int m = 0; m < 2; m++) begin
          if (!wcv[m] && gen_en && roll(p_cmd)) new_wcmd(m);
          if (!rcv[m] && gen_en && roll(p_cmd)) new_rcmd(m);
          mrdy[m] = roll(p_act);
        end
        wv[0] = (wbq0.size() > 0) && roll(p_act);
        wd[0] = (wbq0.size() > 0) ? wbq0[0] : '0;
        wv[1] = (wbq1.size() > 0) && roll(p_act);
        wd[1] = (wbq1.size() > 0) ? wbq1[0] : '0;
        s_wcr = roll(p_srdy);
        s_rcr = roll(p_srdy);
        s_wr  = roll(p_sdat);
        s_rv  = (srq.size() > 0) && roll(p_sdat);
        s_rd  = (srq.size() > 0) ? beat_data(srq[0].addr, sbeat) : '0;
      end
    end
  end

  // scoreboard: outstanding commands as expected beats in downstream order
  typedef struct {
    logic         id;
    logic         last;
    logic [511:0] data;
  } beat_t;

  beat_t exp_w [$];
  beat_t exp_r [$];
  int    wocc = 0, rocc = 0;
  bit    pref_w = 0, pref_r = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs_zero",
            576'(|{o_s_wcmd_valid, o_s_rcmd_valid, o_s_wvalid, o_s_rready, o_s_wcmd_addr,
                   o_s_wcmd_len, o_s_rcmd_addr, o_s_rcmd_len, o_s_wdata, wcr[0], wcr[1],
                   rcr[0], rcr[1], wrdy[0], wrdy[1], rv[0], rv[1], rd[0], rd[1]}), '0);
        exp_w.delete();
        exp_r.delete();
        wocc = 0;
        rocc = 0;
        pref_w = 0;
        pref_r = 0;
      end else begin
        bit          any, w, sp, wpush, rpush, h;
        logic [40:0] e;
        beat_t       b;

        // write command: preferred master wins a tie, the other wins if alone
        any = wcv[0] || wcv[1];
        w   = (wcv[0] && wcv[1]) ? pref_w : wcv[1];
        sp  = (wocc < DEPTH);
        e   = '0;
        if (any) e = {sp, sp && s_wcr && !w, sp && s_wcr && w, wca[w], wcl[w]};
        chk("wcmd", {o_s_wcmd_valid, wcr[0], wcr[1], o_s_wcmd_addr, o_s_wcmd_len}, e);
        wpush = any && sp && s_wcr;
        if (wpush) begin
          for (int k = 0; k <= int'(wcl[w]); k++) begin
            b.id = w;
            b.last = (k == int'(wcl[w]));
            b.data = beat_data(wca[w], k);
            exp_w.push_back(b);
          end
        end

        // write data: the oldest command's master owns the data channel
        if (exp_w.size() == wocc_beats_pending_w()) begin end
        begin
          logic [2:0] e3;
          e3 = '0;
          if (wocc > 0) begin
            h  = exp_w[0].id;
            e3 = {wv[h], s_wr && !h, s_wr && h};
          end
          chk("wdata_ctl", {o_s_wvalid, wrdy[0], wrdy[1]}, e3);
          if (o_s_wvalid && s_wr) begin
            if (wocc == 0) fail("wdata_unexpected");
            else begin
              chk("wdata", o_s_wdata, exp_w[0].data);
              if (exp_w[0].last) wocc--;
              void'(exp_w.pop_front());
            end
          end
        end
        if (wpush) begin
          wocc++;
          pref_w = !w;
        end

        // read command
        any = rcv[0] || rcv[1];
        w   = (rcv[0] && rcv[1]) ? pref_r : rcv[1];
        sp  = (rocc < DEPTH);
        e   = '0;
        if (any) e = {sp, sp && s_rcr && !w, sp && s_rcr && w, rca[w], rcl[w]};
        chk("rcmd", {o_s_rcmd_valid, rcr[0], rcr[1], o_s_rcmd_addr, o_s_rcmd_len}, e);
        rpush = any && sp && s_rcr;

        // read data: returned to the master of the oldest read command
        begin
          logic [2:0] e3;
          e3 = '0;
          if (rocc > 0) begin
            h  = exp_r[0].id;
            e3 = {mrdy[h], s_rv && !h, s_rv && h};
          end
          chk("rdata_ctl", {o_s_rready, rv[0], rv[1]}, e3);
          if (s_rv && o_s_rready) begin
            if (rocc == 0) fail("rdata_unexpected");
            else begin
              h = exp_r[0].id;
              chk("rdata", rd[h], exp_r[0].data);
              if (exp_r[0].last) rocc--;
              void'(exp_r.pop_front());
            end
          end
        end
        if (rpush) begin
          for (int k = 0; k <= int'(rcl[w]); k++) begin
            b.id = w;
            b.last = (k == int'(rcl[w]));
            b.data = beat_data(rca[w], k);
            exp_r.push_back(b);
          end
          rocc++;
          pref_r = !w;
        end
      end
    end
  end

  function automatic int wocc_beats_pending_w();
    return -1;
  endfunction

  initial begin
    bit drained;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    repeat (1500) @(posedge clk);
    // slow slave data side: order queues fill and command ready must close
    p_cmd = 90; p_sdat = 10;
    repeat (1500) @(posedge clk);
    // full rate: back-to-back bursts and alternating grants
    p_cmd = 100; p_act = 100; p_srdy = 100; p_sdat = 100;
    repeat (800) @(posedge clk);
    // reset in the middle of traffic
    p_cmd = 80; p_act = 60; p_srdy = 80; p_sdat = 60;
    repeat (300) @(posedge clk);
    #2 rst = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("post_reset_wgrant_m0", {o_s_wcmd_valid, o_s_wcmd_addr}, {1'b1, wca[0]});
    chk("post_reset_rgrant_m0", {o_s_rcmd_valid, o_s_rcmd_addr}, {1'b1, rca[0]});
    repeat (1000) @(posedge clk);
    // drain everything outstanding
    gen_en = 0; p_act = 100; p_srdy = 100; p_sdat = 100;
    drained = 0;
    for (int i = 0; i < 3000 && !drained; i++) begin
      @(posedge clk);
      drained = (exp_w.size() == 0) && (exp_r.size() == 0) &&
                !wcv[0] && !wcv[1] && !rcv[0] && !rcv[1];
    end
    if (!drained) fail("drain_timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
